// File: rtl/bster_pkg.sv
// bster_pkg: shared FSM state, AXI constants and requester indices for the RAM arbiter
package bster_pkg;
    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        READ,
        RRESP,
        RESP
    } state_e;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam int REQ_SEARCH = 0;
    localparam int REQ_UPDATE = 1;
endpackage

// File: rtl/bster_rr_arbiter.sv
// bster_rr_arbiter: 2-way grant; round-robin with BSTER_ARB_RR_EN, fixed priority (search first) otherwise
module bster_rr_arbiter
    import bster_pkg::*;
(
`ifdef BSTER_ARB_RR_EN
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       accept_i,
`endif
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output logic       idx_o
);
`ifdef BSTER_ARB_RR_EN
    logic ptr_q;
    // Remember the last granted requester so contention alternates; reset favours the search engine
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= 1'b1;
        else if (accept_i) ptr_q <= idx_o;
    end
    assign idx_o = (&req_i) ? !ptr_q : req_i[REQ_UPDATE];
`else
    assign idx_o = !req_i[REQ_SEARCH] && req_i[REQ_UPDATE];
`endif
    assign gnt_o = 2'b01 << idx_o;
endmodule

// File: rtl/bster_ram_arbiter.sv
// bster_ram_arbiter: shares one AXI4 RAM port between search and update engines; BSTER_ARB_RR_EN selects round-robin
module bster_ram_arbiter
    import bster_pkg::*;
#(
    parameter int RAM_DATA_WIDTH = 32,
    parameter int RAM_ADDR_WIDTH = 16,
    parameter int RAM_ID_WIDTH   = 8
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [1:0]                  req_valid,
    output logic [1:0]                  req_ready,
    input  logic [1:0]                  req_wr,
    input  logic [2*RAM_ADDR_WIDTH-1:0] req_addr,
    input  logic [2*RAM_DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]                  rsp_valid,
    input  logic [1:0]                  rsp_ready,
    output logic [RAM_DATA_WIDTH-1:0]   rsp_rdata,
    output logic                        rsp_err,
    output logic [RAM_ID_WIDTH-1:0]     ram_axi_awid,
    output logic [RAM_ADDR_WIDTH-1:0]   ram_axi_awaddr,
    output logic [7:0]                  ram_axi_awlen,
    output logic [2:0]                  ram_axi_awsize,
    output logic [1:0]                  ram_axi_awburst,
    output logic                        ram_axi_awlock,
    output logic [3:0]                  ram_axi_awcache,
    output logic [2:0]                  ram_axi_awprot,
    output logic                        ram_axi_awvalid,
    input  logic                        ram_axi_awready,
    output logic [RAM_DATA_WIDTH-1:0]   ram_axi_wdata,
    output logic [RAM_DATA_WIDTH/8-1:0] ram_axi_wstrb,
    output logic                        ram_axi_wlast,
    output logic                        ram_axi_wvalid,
    input  logic                        ram_axi_wready,
    input  logic [RAM_ID_WIDTH-1:0]     ram_axi_bid,
    input  logic [1:0]                  ram_axi_bresp,
    input  logic                        ram_axi_bvalid,
    output logic                        ram_axi_bready,
    output logic [RAM_ID_WIDTH-1:0]     ram_axi_arid,
    output logic [RAM_ADDR_WIDTH-1:0]   ram_axi_araddr,
    output logic [7:0]                  ram_axi_arlen,
    output logic [2:0]                  ram_axi_arsize,
    output logic [1:0]                  ram_axi_arburst,
    output logic                        ram_axi_arlock,
    output logic [3:0]                  ram_axi_arcache,
    output logic [2:0]                  ram_axi_arprot,
    output logic                        ram_axi_arvalid,
    input  logic                        ram_axi_arready,
    input  logic [RAM_ID_WIDTH-1:0]     ram_axi_rid,
    input  logic [RAM_DATA_WIDTH-1:0]   ram_axi_rdata,
    input  logic [1:0]                  ram_axi_rresp,
    input  logic                        ram_axi_rlast,
    input  logic                        ram_axi_rvalid,
    output logic                        ram_axi_rready
);
    localparam logic [2:0] SIZE = 3'($clog2(RAM_DATA_WIDTH/8));
    state_e                    state_q, state_d;
    logic                      grant_q, grant_d;
    logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [RAM_DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic                      err_q, err_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [1:0]                gnt;
    logic                      gnt_idx, accept, wr_st, rd_st;
    // Acceptance is gated by reset so req_ready reads 0 while aresetn is low
    assign accept = aresetn && state_q == IDLE && |req_valid;
    bster_rr_arbiter u_arb (
`ifdef BSTER_ARB_RR_EN
        .clk_i    (aclk),
        .rst_ni   (aresetn),
        .accept_i (accept),
`endif
        .req_i    (req_valid),
        .gnt_o    (gnt),
        .idx_o    (gnt_idx)
    );
    // State and captured transaction registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end
    // Next-state: accept, run one single-beat AXI transfer, then hold the completion until taken
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: if (accept) begin
                grant_d   = gnt_idx;
                addr_d    = gnt_idx ? req_addr[2*RAM_ADDR_WIDTH-1:RAM_ADDR_WIDTH] : req_addr[RAM_ADDR_WIDTH-1:0];
                wdata_d   = gnt_idx ? req_wdata[2*RAM_DATA_WIDTH-1:RAM_DATA_WIDTH] : req_wdata[RAM_DATA_WIDTH-1:0];
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = req_wr[gnt_idx] ? WRITE : READ;
            end
            WRITE: begin
                aw_done_d = aw_done_q || ram_axi_awready;
                w_done_d  = w_done_q || ram_axi_wready;
                if (aw_done_d && w_done_d) state_d = WRESP;
            end
            WRESP: if (ram_axi_bvalid) begin
                err_d   = (ram_axi_bresp != RESP_OKAY) || (ram_axi_bid != RAM_ID_WIDTH'(grant_q));
                rdata_d = '0;
                state_d = RESP;
            end
            READ: if (ram_axi_arready) state_d = RRESP;
            RRESP: if (ram_axi_rvalid) begin
                rdata_d = ram_axi_rdata;
                err_d   = (ram_axi_rresp != RESP_OKAY) || !ram_axi_rlast || (ram_axi_rid != RAM_ID_WIDTH'(grant_q));
                state_d = RESP;
            end
            RESP: if (rsp_ready[grant_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign wr_st           = state_q == WRITE;
    assign rd_st           = state_q == READ;
    assign req_ready       = accept ? gnt : 2'b00;
    assign rsp_valid       = (state_q == RESP) ? (2'b01 << grant_q) : 2'b00;
    assign rsp_rdata       = rdata_q;
    assign rsp_err         = err_q;
    assign ram_axi_awid    = RAM_ID_WIDTH'(grant_q);
    assign ram_axi_awaddr  = addr_q;
    assign ram_axi_awlen   = 8'd0;
    assign ram_axi_awsize  = wr_st ? SIZE : 3'd0;
    assign ram_axi_awburst = wr_st ? BURST_INCR : 2'b00;
    assign ram_axi_awlock  = 1'b0;
    assign ram_axi_awcache = 4'd0;
    assign ram_axi_awprot  = 3'd0;
    assign ram_axi_awvalid = wr_st && !aw_done_q;
    assign ram_axi_wdata   = wdata_q;
    assign ram_axi_wstrb   = wr_st ? '1 : '0;
    assign ram_axi_wvalid  = wr_st && !w_done_q;
    assign ram_axi_wlast   = ram_axi_wvalid;
    assign ram_axi_bready  = state_q == WRESP;
    assign ram_axi_arid    = RAM_ID_WIDTH'(grant_q);
    assign ram_axi_araddr  = addr_q;
    assign ram_axi_arlen   = 8'd0;
    assign ram_axi_arsize  = rd_st ? SIZE : 3'd0;
    assign ram_axi_arburst = rd_st ? BURST_INCR : 2'b00;
    assign ram_axi_arlock  = 1'b0;
    assign ram_axi_arcache = 4'd0;
    assign ram_axi_arprot  = 3'd0;
    assign ram_axi_arvalid = rd_st;
    assign ram_axi_rready  = state_q == RRESP;
endmodule

// File: doc/bster_ram_arbiter.md
BSTER_RAM_ARBITER -- requirements
Module: bster_ram_arbiter

Interface
REQ-001 Parameter RAM_DATA_WIDTH, default 32, RAM data width in bits.
REQ-002 Parameter RAM_ADDR_WIDTH, default 16, RAM byte address width.
REQ-003 Parameter RAM_ID_WIDTH, default 8, AXI4 ID width.
REQ-004 aclk  in  1  clock; one clock, all logic on rising edge.
REQ-005 aresetn  in  1  reset; asynchronous, active-low.
REQ-006 req_valid  in  2  request valid; bit0 is the search engine, bit1 is the update engine.
REQ-007 req_ready  out  2  request accepted, one bit per requester.
REQ-008 req_wr  in  2  1 = write, 0 = read.
REQ-009 req_addr  in  2*RAM_ADDR_WIDTH  byte address; slice i belongs to requester i.
REQ-010 req_wdata  in  2*RAM_DATA_WIDTH  write data; slice i belongs to requester i.
REQ-011 rsp_valid  out  2  completion valid, one bit per requester.
REQ-012 rsp_ready  in  2  completion accepted, one bit per requester.
REQ-013 rsp_rdata  out  RAM_DATA_WIDTH  read data, shared by both requesters.
REQ-014 rsp_err  out  1  completion error, shared by both requesters.
REQ-015 ram_axi_aw{id,addr,len,size,burst,lock,cache,prot,valid}  out, ram_axi_awready  in  AXI4 AW channel, widths per the bster core RAM port.
REQ-016 ram_axi_w{data,strb,last,valid}  out, ram_axi_wready  in  AXI4 W channel.
REQ-017 ram_axi_b{id,resp,valid}  in, ram_axi_bready  out  AXI4 B channel.
REQ-018 ram_axi_ar{id,addr,len,size,burst,lock,cache,prot,valid}  out, ram_axi_arready  in  AXI4 AR channel.
REQ-019 ram_axi_r{id,data,resp,last,valid}  in, ram_axi_rready  out  AXI4 R channel.

Function
REQ-020 Single outstanding transaction; single-beat only.
- Fixed fields: len=0; size=log2(RAM_DATA_WIDTH/8); burst=INCR (2'b01); lock/cache/prot=0; wstrb all ones; wlast=wvalid.
- aw/ar id = granted index, zero-extended.
REQ-021 FSM states: IDLE, WRITE, WRESP, READ, RRESP, RESP.
REQ-022 IDLE: when any req_valid is high, grant one requester and pulse its req_ready for exactly one cycle (acceptance cycle N).
- Capture wr, addr and wdata in cycle N.
- Next state is WRITE or READ.
- req_ready is 0 in every other state.
REQ-023 Latency: awvalid+wvalid, or arvalid, asserted at cycle N+1.
REQ-024 WRITE: awvalid and wvalid are each held until their own ready, and each is dropped individually after its handshake; both complete -> WRESP.
REQ-025 WRESP: bready=1.
- On bvalid: err = (bresp!=0) | (bid!=grant).
- rsp_rdata = 0.
- Next state RESP.
REQ-026 READ: arvalid held until arready -> RRESP.
REQ-027 RRESP: rready=1.
- On rvalid: capture rdata; err = (rresp!=0) | !rlast | (rid!=grant).
- Next state RESP.
REQ-028 RESP: rsp_valid[grant]=1; rsp_rdata and rsp_err held stable until rsp_ready[grant]; then IDLE.
- Earliest next acceptance is the cycle after the rsp handshake.
REQ-029 A request on the non-granted port waits; its req_valid may stay high indefinitely without effect.
REQ-030 AXI valids are never dropped before their ready (protocol compliance).

Reset
REQ-031 While aresetn is low:
- all outputs are 0, including req_ready, rsp_valid and all AXI valids/readys;
- state is IDLE;
- captured registers are 0;
- the round-robin pointer is 1.
REQ-032 Reset asserted mid-transaction abandons the transaction immediately; no completion is issued after release.
REQ-033 First acceptance is possible on the first clock edge after aresetn deasserts.

Configuration
REQ-034 BSTER_ARB_RR_EN defined: round-robin arbitration.
- On contention, grant the requester not granted last.
- The pointer updates on each acceptance.
- The pointer resets to 1, so requester 0 wins the first contention.
REQ-035 BSTER_ARB_RR_EN undefined: fixed priority; requester 0 always wins, and the pointer logic is absent.

Structure
REQ-036 Shared package bster_pkg holds:
- the FSM state enum;
- AXI constants BURST_INCR and RESP_OKAY;
- requester indices REQ_SEARCH=0 and REQ_UPDATE=1.
REQ-037 One sub-module, bster_rr_arbiter: 2-way grant logic plus pointer, with the macro-controlled behaviour.

Verification
REQ-038 Read requester 0, addr 0x0010, RAM preloaded with 0xDEADBEEF:
- arvalid at N+1 with arid=0, arlen=0, arsize=2;
- rsp_valid[0] with rdata=0xDEADBEEF and err=0.
REQ-039 Write requester 1, addr 0x0020, data 0x12345678:
- aw/w with awid=1, wstrb=4'hF, wlast=1;
- rsp_valid[1] with err=0;
- a subsequent read of 0x0020 returns 0x12345678.
REQ-040 Both requesters hold valid continuously for 4 transactions:
- with RR, grant order is 0,1,0,1;
- without the macro, grant order is 0,0,0,0.
REQ-041 Backpressure: RAM delays awready by 3 cycles and wready by 0, and rsp_ready is held low 5 cycles:
- valids stay asserted until their handshakes;
- rsp_rdata/rsp_err are stable throughout;
- no second grant occurs before the rsp handshake.
REQ-042 Error path: RAM model returns rresp=2'b10 -> rsp_err=1.
REQ-043 Reset mid-flight: aresetn asserted during RRESP:
- all outputs read 0;
- after release, no stale rsp_valid;
- a new request completes normally.
